// File: rtl/cnn_fifo_pkg.sv
// Shared helpers for the CNN conversion FIFOs: constant functions that derive
// geometry from the module parameters and validate a configuration.
package cnn_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

  function automatic int unsigned ram_width(input int unsigned width_in,
                                            input int unsigned ratio);
    return width_in * ratio;
  endfunction

  function automatic int unsigned ngroups(input int unsigned ratio, input int unsigned group);
    return ratio / group;
  endfunction

  function automatic int unsigned word_cap(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  // Ratio must be a power of two >= 2, group must divide it, and dout must fit the entry.
  function automatic bit cfg_ok(input int unsigned width_in, input int unsigned ratio,
                                input int unsigned group, input int unsigned width_out);
    return (width_out >= width_in * ratio) && (group != 0) && (ratio % group == 0) &&
           (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port; infers block RAM.
module sdp_ram #(
  parameter int unsigned WIDTH      = 1024,
  parameter int unsigned DEPTH_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register reset maps onto the block RAM output-latch reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_convert_fifo_gen.sv
// Narrow-to-wide conversion FIFO: packs RATIO input words per RAM entry and returns
// each entry group-reordered and zero-extended, with run-time threshold flags.
module data_convert_fifo_gen
  import cnn_fifo_pkg::*;
#(
  parameter int unsigned WIDTH_IN   = 128,
  parameter int unsigned RATIO      = 8,
  parameter int unsigned GROUP      = 2,
  parameter int unsigned REVERSE    = 1,
  parameter int unsigned WIDTH_OUT  = 2304,
  parameter int unsigned DEPTH_BITS = 7,
  parameter int unsigned ADDR_BITS  = DEPTH_BITS + clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Next_Reg,
  input  logic [WIDTH_IN-1:0]   din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH_OUT-1:0]  dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  input  logic [ADDR_BITS:0]    M_count,
  output logic                  M_Ready,
  input  logic [ADDR_BITS:0]    S_count,
  output logic                  S_Ready,
  output logic [ADDR_BITS:0]    wr_data_count,
  output logic [DEPTH_BITS:0]   rd_data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned RAM_WIDTH = ram_width(WIDTH_IN, RATIO);
  localparam int unsigned NGROUPS   = ngroups(RATIO, GROUP);
  localparam int unsigned GW        = GROUP * WIDTH_IN;
  localparam int unsigned PB        = clog2(RATIO);

  localparam logic [DEPTH_BITS:0] FULL_CNT   = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]  WORD_CAP   = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]  RATIO_STEP = (ADDR_BITS + 1)'(RATIO);
  localparam logic [PB-1:0]       LAST_SLOT  = PB'(RATIO - 1);

  if (!cfg_ok(WIDTH_IN, RATIO, GROUP, WIDTH_OUT)) begin : g_bad_cfg
    $error("data_convert_fifo_gen: invalid WIDTH_OUT/RATIO/GROUP configuration");
  end

  logic                              flush;
  logic                              wr_acc, rd_acc, commit;
  logic [PB-1:0]                     pack_cnt_q;
  logic [RATIO-2:0][WIDTH_IN-1:0]    pack_q;
  logic [DEPTH_BITS-1:0]             wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]               rd_cnt_q, rd_cnt_d;
  logic [ADDR_BITS:0]                wr_cnt_q, wr_cnt_d;
  logic                              dout_valid_q, m_ready_q, s_ready_q;
  logic                              overflow_q, underflow_q;
  logic [RAM_WIDTH-1:0]              ram_rdata;

  assign flush  = rst | Next_Reg;
  assign empty  = (rd_cnt_q == '0);
  assign full   = (rd_cnt_q == FULL_CNT);
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;
  assign commit = wr_acc & (pack_cnt_q == LAST_SLOT);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (commit && !rd_acc) rd_cnt_d = rd_cnt_q + 1'b1;
    else if (!commit && rd_acc) rd_cnt_d = rd_cnt_q - 1'b1;
    wr_cnt_d = wr_cnt_q;
    if (wr_acc) wr_cnt_d = wr_cnt_d + 1'b1;
    if (rd_acc) wr_cnt_d = wr_cnt_d - RATIO_STEP;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      pack_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      if (wr_acc) pack_cnt_q <= pack_cnt_q + 1'b1;
      if (commit) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // The final slot never needs storage: it goes straight from din into the commit.
  always_ff @(posedge clk) begin
    if (wr_acc && !commit) pack_q[pack_cnt_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      dout_valid_q <= 1'b0;
      m_ready_q    <= 1'b0;
      s_ready_q    <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      m_ready_q    <= (wr_cnt_q >= M_count);
      s_ready_q    <= ((WORD_CAP - wr_cnt_q) >= S_count);
      overflow_q   <= overflow_q | (wr_en & full);
      underflow_q  <= underflow_q | (rd_en & empty);
    end
  end

  sdp_ram #(
    .WIDTH      (RAM_WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clk   (clk),
    .rst   (flush),
    .we    (commit),
    .waddr (wr_ptr_q),
    .wdata ({din, pack_q}),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Pure rewiring of the registered RAM output, so dout stays registered.
  always_comb begin
    dout = '0;
    for (int unsigned g = 0; g < NGROUPS; g++) begin
      if (REVERSE != 0) dout[(NGROUPS - 1 - g) * GW +: GW] = ram_rdata[g * GW +: GW];
      else              dout[g * GW +: GW]                 = ram_rdata[g * GW +: GW];
    end
  end

  assign dout_valid    = dout_valid_q;
  assign M_Ready       = m_ready_q;
  assign S_Ready       = s_ready_q;
  assign wr_data_count = wr_cnt_q;
  assign rd_data_count = rd_cnt_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule
